mem_responder: RTL and testbench
================================

# mem_responder

Word-addressed RAM model that serves as the memory end of the core's `mem_valid`/`mem_ready` bus. It accepts one request at a time, inserts a programmable number of wait states, and pulses `mem_ready` for exactly one cycle with read data or write completion. It serves both instruction and data fetches and is the back end for simulation benches and formal harnesses that need a legal, stalling responder instead of free `mem_rdata` inputs.

## Interface
- `WORDS`, 1024: RAM depth in 32-bit words; must be a power of two, minimum 4.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be aligned to `WORDS*4`.
- `WAIT_CYCLES`, 1: fixed wait states between accept and response, 0..15.

- `clk`  in  1  clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mem_valid`  in  1  request present.
- `mem_instr`  in  1  request is an instruction fetch; informational, no behavioural effect.
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte-lane write enables; 0 means read.
- `mem_ready`  out  1  one-cycle response pulse.
- `mem_rdata`  out  32  read data; valid only while `mem_ready`=1.
- `fault`  out  1  sticky; cleared only by reset.

## Operation
- **State machine:** states IDLE, WAIT and RESP.
- **IDLE:**
  - If `mem_valid`=1, latch `mem_addr`, `mem_wdata` and `mem_wstrb`, and load the wait counter with `WAIT_CYCLES`.
  - Go to WAIT if the counter is nonzero, otherwise to RESP.
- **WAIT:** decrement the counter each cycle; move to RESP on the cycle the counter reaches 0.
- **RESP:**
  - `mem_ready`=1 for exactly one cycle, then return to IDLE.
  - A write commits in this cycle, to the lanes whose `mem_wstrb` bit is set.
  - A read drives `mem_rdata` with the word at the latched address, or 0 for a faulting read.
  - A write response drives `mem_rdata`=0.
- **Address decode:**
  - Word index = (`addr` − `BASE_ADDR`)[log2(WORDS)+1:2].
  - The address is in range iff `addr` − `BASE_ADDR` < `WORDS*4` (unsigned, 32-bit wrap).
- **Fault:** triggered by an out-of-range address or by `addr[1:0]`≠0.
  - The faulting write is dropped and the faulting read returns 0.
  - `fault` is set in the RESP cycle.
  - The transaction still completes normally, with `mem_ready` pulsed.
- **Initiator contract:**
  - Request fields are held stable from `mem_valid` rising until the `mem_ready` cycle.
  - `mem_valid` either drops, or presents a new request, in the cycle after `mem_ready`.
  - The responder samples fields only at accept. Later changes are ignored, not flagged.
- **Outputs outside RESP:** `mem_ready`=0 and `mem_rdata`=0.
- **Storage:** RAM contents are not initialised and are unaffected by reset.

## Timing
- **Reset values:** `mem_ready`=0, `mem_rdata`=0, `fault`=0, state IDLE, counter 0; takes effect asynchronously on `reset_n` falling.
- **Latency:** a request accepted in cycle T gets `mem_ready`=1 in cycle T+1+`WAIT_CYCLES`.
- **Back-to-back:** `mem_valid` high in the cycle after `mem_ready` is accepted as a new request. Peak throughput is one transaction per 2+`WAIT_CYCLES` cycles.
- **Reset mid-transaction:** the transaction is aborted with no RAM write and no `mem_ready`. RAM keeps its prior contents.
- **Simultaneous events:** no request is accepted during WAIT or RESP.
- **Read-after-write:** a read of the same word accepted after a write's RESP returns the new data.
- **Outputs:** all are registered; none depends combinationally on the inputs.

## Configuration
- **`MEM_RAND_WAIT_EN` defined:**
  - Adds a 16-bit Fibonacci LFSR: seed 16'hACE1, taps 16,14,13,11, reset to the seed.
  - The LFSR advances once per accepted request.
  - The wait counter loads `WAIT_CYCLES` + `lfsr[1:0]`, giving latency T+1+`WAIT_CYCLES`..T+4+`WAIT_CYCLES`.
- **`MEM_RAND_WAIT_EN` undefined:** no LFSR is present and latency is exactly fixed.

## Test plan
- **Write then read:** `WAIT_CYCLES`=1, write 32'hDEAD_BEEF to 0x10 with strb 4'hF, then read 0x10 → `mem_ready` 2 cycles after each accept; read returns 32'hDEAD_BEEF.
- **Byte strobes:** write 32'h1122_3344 to 0x20 with strb 4'hF, then 32'hAABB_CCDD with strb 4'b0101, then read 0x20 → 32'h11BB_33DD.
- **Zero-wait back-to-back:** `WAIT_CYCLES`=0, with `mem_valid` held high across reads of 0x0, 0x4 and 0x8 → `mem_ready` every second cycle; exactly 3 pulses; data matches prior writes.
- **Fault:** read 0x1002 with `WORDS`=1024 → `mem_rdata`=0, `mem_ready` pulses, `fault` rises and stays high. Write to `BASE_ADDR`+4096 → RAM unchanged.
- **Reset mid-WAIT:** `WAIT_CYCLES`=3, write 32'h5 to 0x0, deassert `reset_n` during WAIT → no `mem_ready`, all outputs 0. After reset, read 0x0 → old value, not 5.
- **Random wait with `MEM_RAND_WAIT_EN`:** 64 reads → every latency within 1+`WAIT_CYCLES`..4+`WAIT_CYCLES`, and at least two distinct latencies observed.

Source files
------------

// File: rtl/mem_responder.sv
// Word-addressed RAM responder for the mem_valid/mem_ready bus with programmable wait states.
// Optional feature: define MEM_RAND_WAIT_EN to add LFSR-driven extra wait states (0..3).
module mem_responder #(
    parameter int          WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        fault
);
    localparam int          AW   = $clog2(WORDS);
    localparam logic [31:0] SPAN = 32'(WORDS * 4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_r;
    logic [4:0]    cnt_r;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;
    logic [3:0]    wstrb_r;
    logic          mem_ready_r;
    logic [31:0]   mem_rdata_r;
    logic          fault_r;
    logic [31:0]   ram_r [WORDS];

    logic          accept_s;
    logic [4:0]    load_s;
    logic          go_resp_s;
    logic [31:0]   eff_addr_s;
    logic [31:0]   eff_wdata_s;
    logic [3:0]    eff_wstrb_s;
    logic [31:0]   off_s;
    logic          bad_s;
    logic          is_write_s;
    logic [AW-1:0] idx_s;
    logic          ram_we_s;
    logic          unused_instr_s;

    assign unused_instr_s = mem_instr;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

`ifdef MEM_RAND_WAIT_EN
    logic [15:0] lfsr_r;

    // Fibonacci LFSR (taps 16,14,13,11) stepped once per accepted request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_r <= 16'hACE1;
        end else if (accept_s) begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end

    assign load_s = 5'(WAIT_CYCLES) + {3'b000, lfsr_r[1:0]};
`else
    assign load_s = 5'(WAIT_CYCLES);
`endif

    // In IDLE the live bus fields are used so a zero-wait request can be served
    // on the same edge that accepts it; afterwards the latched copies apply.
    always_comb begin
        accept_s = (state_r == ST_IDLE) && mem_valid;
        if (state_r == ST_IDLE) begin
            eff_addr_s  = mem_addr;
            eff_wdata_s = mem_wdata;
            eff_wstrb_s = mem_wstrb;
        end else begin
            eff_addr_s  = addr_r;
            eff_wdata_s = wdata_r;
            eff_wstrb_s = wstrb_r;
        end
        go_resp_s  = (accept_s && (load_s == 5'd0)) ||
                     ((state_r == ST_WAIT) && (cnt_r <= 5'd1));
        off_s      = eff_addr_s - BASE_ADDR;
        bad_s      = (off_s >= SPAN) || (eff_addr_s[1:0] != 2'b00);
        is_write_s = (eff_wstrb_s != 4'b0000);
        idx_s      = off_s[AW+1:2];
        ram_we_s   = go_resp_s && is_write_s && !bad_s && reset_n;
    end

    // RAM array: no reset, contents survive reset_n.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[idx_s] <= merge_bytes(ram_r[idx_s], eff_wdata_s, eff_wstrb_s);
        end
    end

    // Request FSM with registered response outputs and sticky fault flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 5'd0;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            wstrb_r     <= 4'd0;
            mem_ready_r <= 1'b0;
            mem_rdata_r <= 32'd0;
            fault_r     <= 1'b0;
        end else begin
            mem_ready_r <= go_resp_s;
            if (go_resp_s && !is_write_s && !bad_s) begin
                mem_rdata_r <= ram_r[idx_s];
            end else begin
                mem_rdata_r <= 32'd0;
            end
            if (go_resp_s && bad_s) begin
                fault_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        addr_r  <= mem_addr;
                        wdata_r <= mem_wdata;
                        wstrb_r <= mem_wstrb;
                        cnt_r   <= load_s;
                        state_r <= (load_s == 5'd0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 5'd1;
                    if (cnt_r <= 5'd1) begin
                        state_r <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 5'd0;
                end
            endcase
        end
    end

    assign mem_ready = mem_ready_r;
    assign mem_rdata = mem_rdata_r;
    assign fault     = fault_r;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with WAIT_CYCLES 1, 0 and 3.
module tb_mem_responder;
    localparam int W0 = 1;
    localparam int W1 = 0;
    localparam int W2 = 3;
`ifdef MEM_RAND_WAIT_EN
    localparam int EXTRA = 3;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk;
    logic        rst_n_v [3];
    logic        valid_v [3];
    logic        instr_v [3];
    logic [31:0] addr_v  [3];
    logic [31:0] wdata_v [3];
    logic [3:0]  wstrb_v [3];
    logic        ready_v [3];
    logic [31:0] rdata_v [3];
    logic        fault_v [3];

    int checks;
    int failures;

    mem_responder #(.WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .reset_n(rst_n_v[0]), .mem_valid(valid_v[0]), .mem_instr(instr_v[0]),
        .mem_addr(addr_v[0]), .mem_wdata(wdata_v[0]), .mem_wstrb(wstrb_v[0]),
        .mem_ready(ready_v[0]), .mem_rdata(rdata_v[0]), .fault(fault_v[0]));

    mem_responder #(.WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .reset_n(rst_n_v[1]), .mem_valid(valid_v[1]), .mem_instr(instr_v[1]),
        .mem_addr(addr_v[1]), .mem_wdata(wdata_v[1]), .mem_wstrb(wstrb_v[1]),
        .mem_ready(ready_v[1]), .mem_rdata(rdata_v[1]), .fault(fault_v[1]));

    mem_responder #(.WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(W2)) dut2 (
        .clk(clk), .reset_n(rst_n_v[2]), .mem_valid(valid_v[2]), .mem_instr(instr_v[2]),
        .mem_addr(addr_v[2]), .mem_wdata(wdata_v[2]), .mem_wstrb(wstrb_v[2]),
        .mem_ready(ready_v[2]), .mem_rdata(rdata_v[2]), .fault(fault_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction on instance i; lat is cycles from accept to mem_ready, -1 on timeout.
    task automatic do_txn(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int lat, output logic [31:0] rd);
        @(negedge clk);
        valid_v[i] = 1'b1;
        addr_v[i]  = a;
        wdata_v[i] = d;
        wstrb_v[i] = s;
        lat = -1;
        rd  = 32'd0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (ready_v[i] === 1'b1) begin
                lat = n;
                rd  = rdata_v[i];
                break;
            end
        end
        valid_v[i] = 1'b0;
        wstrb_v[i] = 4'd0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            rst_n_v[i] = 1'b0;
            valid_v[i] = 1'b0;
            instr_v[i] = 1'b0;
            addr_v[i]  = 32'd0;
            wdata_v[i] = 32'd0;
            wstrb_v[i] = 4'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ready_v[i] !== 1'b0 || rdata_v[i] !== 32'd0 || fault_v[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_state inst=%0d got ready=%b rdata=%h fault=%b want 0/0/0",
                         i, ready_v[i], rdata_v[i], fault_v[i]);
            end
            rst_n_v[i] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int lat;
        logic [31:0] rd;
        do_txn(0, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, rd);
        checks++;
        if (lat < 1 + W0 || lat > 1 + W0 + EXTRA) begin
            failures++;
            $display("FAIL wr_latency got %0d want %0d", lat, 1 + W0);
        end
        checks++;
        if (rd !== 32'd0) begin
            failures++;
            $display("FAIL wr_rdata got %h want 00000000", rd);
        end
        do_txn(0, 32'h10, 32'd0, 4'h0, lat, rd);
        checks++;
        if (lat < 1 + W0 || lat > 1 + W0 + EXTRA) begin
            failures++;
            $display("FAIL rd_latency got %0d want %0d", lat, 1 + W0);
        end
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL rd_data got %h want deadbeef", rd);
        end
        @(negedge clk);
        checks++;
        if (ready_v[0] !== 1'b0 || rdata_v[0] !== 32'd0) begin
            failures++;
            $display("FAIL idle_outputs got ready=%b rdata=%h want 0/0", ready_v[0], rdata_v[0]);
        end
    endtask

    task automatic test_byte_strobes();
        int lat;
        logic [31:0] rd;
        do_txn(0, 32'h20, 32'h1122_3344, 4'hF, lat, rd);
        do_txn(0, 32'h20, 32'hAABB_CCDD, 4'b0101, lat, rd);
        do_txn(0, 32'h20, 32'd0, 4'h0, lat, rd);
        checks++;
        if (rd !== 32'h11BB_33DD) begin
            failures++;
            $display("FAIL byte_strobes got %h want 11bb33dd", rd);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int k;
        int last_c;
        logic [31:0] rd;
        logic [31:0] exp_d [3];
        exp_d[0] = 32'h0000_0A00;
        exp_d[1] = 32'h0000_0B04;
        exp_d[2] = 32'h0000_0C08;
        for (int j = 0; j < 3; j++) begin
            do_txn(1, 32'(4 * j), exp_d[j], 4'hF, lat, rd);
        end
        @(negedge clk);
        valid_v[1] = 1'b1;
        addr_v[1]  = 32'h0;
        wstrb_v[1] = 4'h0;
        k = 0;
        last_c = -1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (ready_v[1] === 1'b1) begin
                checks++;
                if (k < 3 && rdata_v[1] !== exp_d[k]) begin
                    failures++;
                    $display("FAIL b2b_data idx=%0d got %h want %h", k, rdata_v[1], exp_d[k]);
                end
`ifndef MEM_RAND_WAIT_EN
                checks++;
                if (c != 2 * k + 1) begin
                    failures++;
                    $display("FAIL b2b_timing idx=%0d got cycle %0d want %0d (prev %0d)",
                             k, c, 2 * k + 1, last_c);
                end
`endif
                last_c = c;
                k++;
                if (k < 3) begin
                    addr_v[1] = 32'(4 * k);
                end else begin
                    valid_v[1] = 1'b0;
                end
            end
        end
        checks++;
        if (k != 3) begin
            failures++;
            $display("FAIL b2b_pulses got %0d want 3", k);
        end
    endtask

    task automatic test_fault();
        int lat;
        logic [31:0] rd;
        do_txn(0, 32'h0, 32'hCAFE_F00D, 4'hF, lat, rd);
        checks++;
        if (fault_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL fault_pre got %b want 0", fault_v[0]);
        end
        do_txn(0, 32'h1002, 32'd0, 4'h0, lat, rd);
        checks++;
        if (lat < 1 + W0 || lat > 1 + W0 + EXTRA) begin
            failures++;
            $display("FAIL fault_rd_latency got %0d want %0d", lat, 1 + W0);
        end
        checks++;
        if (rd !== 32'd0) begin
            failures++;
            $display("FAIL fault_rd_data got %h want 00000000", rd);
        end
        checks++;
        if (fault_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL fault_set got %b want 1", fault_v[0]);
        end
        do_txn(0, 32'h1000, 32'h1234_5678, 4'hF, lat, rd);
        repeat (3) @(negedge clk);
        checks++;
        if (fault_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL fault_sticky got %b want 1", fault_v[0]);
        end
        do_txn(0, 32'h0, 32'd0, 4'h0, lat, rd);
        checks++;
        if (rd !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL fault_wr_dropped got %h want cafef00d", rd);
        end
    endtask

    task automatic test_reset_mid_wait();
        int lat;
        logic [31:0] rd;
        do_txn(2, 32'h0, 32'h0000_0077, 4'hF, lat, rd);
        @(negedge clk);
        valid_v[2] = 1'b1;
        addr_v[2]  = 32'h0;
        wdata_v[2] = 32'h0000_0005;
        wstrb_v[2] = 4'hF;
        @(negedge clk);
        checks++;
        if (ready_v[2] !== 1'b0) begin
            failures++;
            $display("FAIL midwait_ready_pre got %b want 0", ready_v[2]);
        end
        rst_n_v[2] = 1'b0;
        valid_v[2] = 1'b0;
        wstrb_v[2] = 4'h0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (ready_v[2] !== 1'b0 || rdata_v[2] !== 32'd0 || fault_v[2] !== 1'b0) begin
                failures++;
                $display("FAIL midwait_outputs c=%0d got ready=%b rdata=%h fault=%b want 0/0/0",
                         c, ready_v[2], rdata_v[2], fault_v[2]);
            end
            @(negedge clk);
        end
        rst_n_v[2] = 1'b1;
        do_txn(2, 32'h0, 32'd0, 4'h0, lat, rd);
        checks++;
        if (lat < 1 + W2 || lat > 1 + W2 + EXTRA || rd !== 32'h0000_0077) begin
            failures++;
            $display("FAIL midwait_ram got lat=%0d data=%h want lat=%0d data=00000077",
                     lat, rd, 1 + W2);
        end
    endtask

`ifdef MEM_RAND_WAIT_EN
    task automatic test_rand_wait();
        int lat;
        int lo;
        int hi;
        logic [31:0] rd;
        lo = 99;
        hi = -1;
        for (int n = 0; n < 64; n++) begin
            do_txn(0, 32'h10, 32'd0, 4'h0, lat, rd);
            checks++;
            if (lat < 1 + W0 || lat > 4 + W0) begin
                failures++;
                $display("FAIL rand_latency n=%0d got %0d want %0d..%0d", n, lat, 1 + W0, 4 + W0);
            end
            if (lat < lo) lo = lat;
            if (lat > hi) hi = lat;
        end
        checks++;
        if (lo == hi) begin
            failures++;
            $display("FAIL rand_distinct got single latency %0d want at least two", lo);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_write_read();
        test_byte_strobes();
        test_back_to_back();
        test_fault();
        test_reset_mid_wait();
`ifdef MEM_RAND_WAIT_EN
        test_rand_wait();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
